// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the APB request arbiter.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    localparam int unsigned DEF_ADDR_WIDTH     = 32;
    localparam int unsigned DEF_DATA_WIDTH     = 32;
    localparam int unsigned DEF_NUM_REQ        = 4;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;

    // Width of a requester index; never below one bit.
    function automatic int unsigned grant_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/apb_rr_pick.sv
// Combinational round-robin picker: first set request at or above i_ptr,
// wrapping modulo NUM_REQ.
module apb_rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned GRANT_W = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [GRANT_W-1:0] i_ptr,
    output logic               o_found,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [GRANT_W-1:0] o_idx
);

    logic [GRANT_W-1:0] w_cand;

    // Scan candidates in priority order starting from the pointer.
    always_comb begin
        o_found = 1'b0;
        o_grant = '0;
        o_idx   = '0;
        w_cand  = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_cand = GRANT_W'((32'(i_ptr) + k) % NUM_REQ);
            if (!o_found && i_req[w_cand]) begin
                o_found         = 1'b1;
                o_idx           = w_cand;
                o_grant[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master command port among NUM_REQ
// requesters. Optional busy watchdog enabled by APB_ARB_TIMEOUT_EN.
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned NUM_REQ        = DEF_NUM_REQ,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ-1:0]            wr_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i,
    output logic [NUM_REQ-1:0]            ack_o,
    output logic [DATA_WIDTH-1:0]         rdata_o,
    output logic                          slverr_o,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic                          busy_o,
    output logic                          m_req,
    output logic                          m_wr,
    output logic [ADDR_WIDTH-1:0]         m_addr,
    output logic [DATA_WIDTH-1:0]         m_wdata,
    input  logic                          m_ready,
    input  logic                          m_slverr,
    input  logic [DATA_WIDTH-1:0]         m_rdata,
    output logic                          timeout_o
);

    localparam int unsigned GRANT_W = grant_w(NUM_REQ);

    arb_state_t              r_state,  w_state_nxt;
    logic [GRANT_W-1:0]      r_ptr,    w_ptr_nxt;
    logic [GRANT_W-1:0]      r_gidx,   w_gidx_nxt;
    logic [NUM_REQ-1:0]      r_grant,  w_grant_nxt;
    logic [NUM_REQ-1:0]      r_ack,    w_ack_nxt;
    logic                    r_busy,   w_busy_nxt;
    logic                    r_m_req,  w_m_req_nxt;
    logic                    r_m_wr,   w_m_wr_nxt;
    logic [ADDR_WIDTH-1:0]   r_m_addr, w_m_addr_nxt;
    logic [DATA_WIDTH-1:0]   r_m_wdata, w_m_wdata_nxt;
    logic [DATA_WIDTH-1:0]   r_rdata,  w_rdata_nxt;
    logic                    r_slverr, w_slverr_nxt;

    logic                    w_found;
    logic [NUM_REQ-1:0]      w_pick_grant;
    logic [GRANT_W-1:0]      w_pick_idx;

    apb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .GRANT_W (GRANT_W)
    ) u_pick (
        .i_req   (req_i),
        .i_ptr   (r_ptr),
        .o_found (w_found),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_gidx    <= '0;
            r_grant   <= '0;
            r_ack     <= '0;
            r_busy    <= 1'b0;
            r_m_req   <= 1'b0;
            r_m_wr    <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            r_rdata   <= '0;
            r_slverr  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_gidx    <= w_gidx_nxt;
            r_grant   <= w_grant_nxt;
            r_ack     <= w_ack_nxt;
            r_busy    <= w_busy_nxt;
            r_m_req   <= w_m_req_nxt;
            r_m_wr    <= w_m_wr_nxt;
            r_m_addr  <= w_m_addr_nxt;
            r_m_wdata <= w_m_wdata_nxt;
            r_rdata   <= w_rdata_nxt;
            r_slverr  <= w_slverr_nxt;
        end
    end

    // Next-state and registered-output logic for IDLE -> BUSY -> DONE.
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_gidx_nxt    = r_gidx;
        w_grant_nxt   = r_grant;
        w_ack_nxt     = '0;
        w_busy_nxt    = r_busy;
        w_m_req_nxt   = r_m_req;
        w_m_wr_nxt    = r_m_wr;
        w_m_addr_nxt  = r_m_addr;
        w_m_wdata_nxt = r_m_wdata;
        w_rdata_nxt   = r_rdata;
        w_slverr_nxt  = r_slverr;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_nxt   = BUSY;
                    w_gidx_nxt    = w_pick_idx;
                    w_grant_nxt   = w_pick_grant;
                    w_busy_nxt    = 1'b1;
                    w_m_req_nxt   = 1'b1;
                    w_m_wr_nxt    = wr_i[w_pick_idx];
                    w_m_addr_nxt  = addr_i[w_pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    w_m_wdata_nxt = wdata_i[w_pick_idx*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            BUSY: begin
                if (m_ready) begin
                    w_state_nxt  = DONE;
                    w_rdata_nxt  = m_rdata;
                    w_slverr_nxt = m_slverr;
                    w_ack_nxt    = r_grant;
                    w_m_req_nxt  = 1'b0;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
                w_busy_nxt  = 1'b0;
                w_ptr_nxt   = (r_gidx == GRANT_W'(NUM_REQ - 1)) ? '0 : r_gidx + 1'b1;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

`ifdef APB_ARB_TIMEOUT_EN
    localparam int unsigned TCNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TCNT_W-1:0] r_tcnt,    w_tcnt_nxt;
    logic              r_timeout, w_timeout_nxt;

    // Watchdog registers; the flag is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tcnt    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_tcnt    <= w_tcnt_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    // Counter clears while idle so it starts at zero on BUSY entry; saturates.
    always_comb begin
        w_tcnt_nxt    = r_tcnt;
        w_timeout_nxt = r_timeout;
        if (r_state == IDLE) begin
            w_tcnt_nxt = '0;
        end else if (r_state == BUSY && !m_ready) begin
            if (32'(r_tcnt) < TIMEOUT_CYCLES) begin
                w_tcnt_nxt = r_tcnt + 1'b1;
            end
            if (32'(r_tcnt) + 32'd1 >= TIMEOUT_CYCLES) begin
                w_timeout_nxt = 1'b1;
            end
        end
    end

    assign timeout_o = r_timeout;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = |TIMEOUT_CYCLES;
    assign timeout_o        = 1'b0;
`endif

    assign ack_o    = r_ack;
    assign rdata_o  = r_rdata;
    assign slverr_o = r_slverr;
    assign grant_o  = r_grant;
    assign busy_o   = r_busy;
    assign m_req    = r_m_req;
    assign m_wr     = r_m_wr;
    assign m_addr   = r_m_addr;
    assign m_wdata  = r_m_wdata;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: directed scenarios plus random
// traffic against a transaction-level reference model.
module tb_apb_req_arbiter;

    localparam int NR = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;
    localparam int GW = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NR-1:0]        req_i = '0;
    logic [NR-1:0]        wr_i = '0;
    logic [NR*AW-1:0]     addr_i;
    logic [NR*DW-1:0]     wdata_i;
    logic [NR-1:0]        ack_o;
    logic [DW-1:0]        rdata_o;
    logic                 slverr_o;
    logic [NR-1:0]        grant_o;
    logic                 busy_o;
    logic                 m_req;
    logic                 m_wr;
    logic [AW-1:0]        m_addr;
    logic [DW-1:0]        m_wdata;
    logic                 m_ready = 1'b0;
    logic                 m_slverr = 1'b0;
    logic [DW-1:0]        m_rdata = '0;
    logic                 timeout_o;

    logic [AW-1:0]        b_addr  [NR];
    logic [DW-1:0]        b_wdata [NR];

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    int exp_order [5] = '{0, 1, 2, 3, 0};

    apb_req_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .NUM_REQ        (NR),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req_i),
        .wr_i      (wr_i),
        .addr_i    (addr_i),
        .wdata_i   (wdata_i),
        .ack_o     (ack_o),
        .rdata_o   (rdata_o),
        .slverr_o  (slverr_o),
        .grant_o   (grant_o),
        .busy_o    (busy_o),
        .m_req     (m_req),
        .m_wr      (m_wr),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_ready   (m_ready),
        .m_slverr  (m_slverr),
        .m_rdata   (m_rdata),
        .timeout_o (timeout_o)
    );

    always #5 clk = ~clk;

    always_comb begin
        addr_i  = '0;
        wdata_i = '0;
        for (int k = 0; k < NR; k++) begin
            addr_i[k*AW +: AW]  = b_addr[k[GW-1:0]];
            wdata_i[k*DW +: DW] = b_wdata[k[GW-1:0]];
        end
    end

    // ---------------- reference model (transaction level) ----------------
    // e_phase: 0 = no transaction, 1 = command issued awaiting completion,
    // 2 = completion being acknowledged.
    int            e_phase = 0;
    int            e_ptr   = 0;
    int            e_win   = 0;
    int            e_tcnt  = 0;
    int            c_idx   = 0;
    bit            found   = 1'b0;
    logic [NR-1:0] e_ack = '0, e_grant = '0;
    logic          e_busy = 1'b0, e_mreq = 1'b0, e_mwr = 1'b0, e_slverr = 1'b0, e_timeout = 1'b0;
    logic [AW-1:0] e_maddr = '0;
    logic [DW-1:0] e_mwdata = '0, e_rdata = '0;

    always @(posedge clk) begin
        if (rst) begin
            e_phase = 0; e_ptr = 0; e_win = 0; e_tcnt = 0;
            e_ack = '0; e_grant = '0; e_busy = 1'b0; e_mreq = 1'b0; e_mwr = 1'b0;
            e_maddr = '0; e_mwdata = '0; e_rdata = '0; e_slverr = 1'b0; e_timeout = 1'b0;
        end else begin
            e_ack = '0;
            if (e_phase == 0) begin
                found = 1'b0;
                for (int i = 0; i < NR; i++) begin
                    c_idx = (e_ptr + i) % NR;
                    if (!found && req_i[c_idx[GW-1:0]]) begin
                        found = 1'b1;
                        e_win = c_idx;
                    end
                end
                if (found) begin
                    e_phase  = 1;
                    e_tcnt   = 0;
                    e_grant  = NR'(1) << e_win;
                    e_busy   = 1'b1;
                    e_mreq   = 1'b1;
                    e_mwr    = wr_i[e_win[GW-1:0]];
                    e_maddr  = b_addr[e_win[GW-1:0]];
                    e_mwdata = b_wdata[e_win[GW-1:0]];
                end
            end else if (e_phase == 1) begin
                if (m_ready) begin
                    e_phase  = 2;
                    e_ack    = NR'(1) << e_win;
                    e_rdata  = m_rdata;
                    e_slverr = m_slverr;
                    e_mreq   = 1'b0;
                end else begin
                    e_tcnt = e_tcnt + 1;
`ifdef APB_ARB_TIMEOUT_EN
                    if (e_tcnt >= TO) e_timeout = 1'b1;
`endif
                end
            end else begin
                e_phase = 0;
                e_grant = '0;
                e_busy  = 1'b0;
                e_ptr   = (e_win + 1) % NR;
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge and compare every output to the model.
    task automatic tick();
        @(negedge clk);
        if (chk_en) begin
            check("ack_o",     ack_o,     e_ack);
            check("rdata_o",   rdata_o,   e_rdata);
            check("slverr_o",  slverr_o,  e_slverr);
            check("grant_o",   grant_o,   e_grant);
            check("busy_o",    busy_o,    e_busy);
            check("m_req",     m_req,     e_mreq);
            check("m_wr",      m_wr,      e_mwr);
            check("m_addr",    m_addr,    e_maddr);
            check("m_wdata",   m_wdata,   e_mwdata);
            check("timeout_o", timeout_o, e_timeout);
        end
    endtask

    function automatic int oh_idx(input logic [NR-1:0] g);
        oh_idx = -1;
        for (int i = 0; i < NR; i++) if (g[i[GW-1:0]]) oh_idx = i;
    endfunction

    task automatic wait_mreq(output int n);
        n = 0;
        while (!m_req && n < 30) begin
            tick();
            n++;
        end
        if (!m_req) check("mreq_wait", 64'(m_req), 64'd1);
    endtask

    task automatic pulse_ready(input logic [DW-1:0] rd, input bit se);
        m_ready  = 1'b1;
        m_rdata  = rd;
        m_slverr = se;
        tick();
        m_ready  = 1'b0;
    endtask

    task automatic set_cmd(input int k, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_i[k[GW-1:0]]    = wr;
        b_addr[k[GW-1:0]]  = a;
        b_wdata[k[GW-1:0]] = d;
    endtask

    task automatic xfer(input int k, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int dly, input logic [DW-1:0] rd, input bit se);
        int gap;
        set_cmd(k, wr, a, d);
        req_i[k[GW-1:0]] = 1'b1;
        wait_mreq(gap);
        check("x_grant", grant_o, 64'(1) << k);
        check("x_addr",  m_addr,  a);
        check("x_wdata", m_wdata, d);
        check("x_wr",    m_wr,    wr);
        repeat (dly) tick();
        pulse_ready(rd, se);
        check("x_ack",    ack_o,    64'(1) << k);
        check("x_rdata",  rdata_o,  rd);
        check("x_slverr", slverr_o, se);
        req_i[k[GW-1:0]] = 1'b0;
        tick();
        check("x_ack_clr",  ack_o,  64'd0);
        check("x_busy_low", busy_o, 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int gap;
        for (int k = 0; k < NR; k++) begin
            b_addr[k[GW-1:0]]  = '0;
            b_wdata[k[GW-1:0]] = '0;
        end
        repeat (2) tick();
        chk_en = 1'b1;
        tick();
        check("rst_m_req",  m_req,     64'd0);
        check("rst_ack",    ack_o,     64'd0);
        check("rst_grant",  grant_o,   64'd0);
        check("rst_busy",   busy_o,    64'd0);
        check("rst_rdata",  rdata_o,   64'd0);
        check("rst_to",     timeout_o, 64'd0);
        rst = 1'b0;
        tick();

        // Single write, completion three cycles after m_req.
        xfer(0, 1'b1, 32'h10, 32'hA5, 2, 32'h0000_1234, 1'b0);
        // Read return on requester 2.
        xfer(2, 1'b0, 32'h20, 32'h0, 1, 32'hDEAD_BEEF, 1'b0);

        // Full contention from a freshly reset pointer.
        do_reset();
        for (int k = 0; k < NR; k++) set_cmd(k, 1'b1, AW'(k * 32'h100), DW'(k + 1));
        req_i = '1;
        for (int i = 0; i < 5; i++) begin
            wait_mreq(gap);
            if (i > 0) check("cont_gap", 64'(gap), 64'd2);
            check("cont_order", 64'(oh_idx(grant_o)), 64'(exp_order[i]));
            tick();
            pulse_ready(DW'(32'hC0DE_0000 + i), 1'b0);
            if (i == 4) req_i = '0;
        end
        tick();

        // Serve 1 so the pointer sits at 2, then 0 and 3 contend: 3 wins first.
        xfer(1, 1'b0, 32'h44, 32'h0, 1, 32'h1111_1111, 1'b0);
        set_cmd(0, 1'b1, 32'h50, 32'h5);
        set_cmd(3, 1'b0, 32'h53, 32'h0);
        req_i = 4'b1001;
        wait_mreq(gap);
        check("rot_first", grant_o, 64'b1000);
        tick();
        pulse_ready(32'h3333_3333, 1'b0);
        check("rot_ack3", ack_o, 64'b1000);
        req_i[3] = 1'b0;
        wait_mreq(gap);
        check("rot_second", grant_o, 64'b0001);
        pulse_ready(32'h0, 1'b0);
        req_i[0] = 1'b0;
        tick();

        // Error response, then a clean one clears the flag.
        xfer(1, 1'b0, 32'h30, 32'h0, 1, 32'hBAD0_BAD0, 1'b1);
        xfer(0, 1'b0, 32'h40, 32'h0, 1, 32'h0000_600D, 1'b0);

        // Reset while BUSY: no ack, pointer returns to 0.
        set_cmd(2, 1'b1, 32'h77, 32'h77);
        req_i = 4'b0100;
        wait_mreq(gap);
        check("rb_grant", grant_o, 64'b0100);
        rst = 1'b1;
        for (int k = 0; k < NR; k++) set_cmd(k, 1'b0, AW'(32'h900 + k), 32'h0);
        req_i = '1;
        tick();
        check("rb_m_req",  m_req,    64'd0);
        check("rb_ack",    ack_o,    64'd0);
        check("rb_grant0", grant_o,  64'd0);
        check("rb_busy",   busy_o,   64'd0);
        check("rb_rdata",  rdata_o,  64'd0);
        check("rb_slverr", slverr_o, 64'd0);
        check("rb_addr",   m_addr,   64'd0);
        rst = 1'b0;
        tick();
        check("rb_ptr0", grant_o, 64'b0001);
        pulse_ready(32'hABCD_0000, 1'b0);
        check("rb_ack0", ack_o, 64'b0001);
        req_i = '0;
        repeat (2) tick();

`ifdef APB_ARB_TIMEOUT_EN
        // Withheld completion trips the sticky watchdog after TO busy cycles.
        do_reset();
        set_cmd(1, 1'b1, 32'h60, 32'h6);
        req_i = 4'b0010;
        wait_mreq(gap);
        repeat (TO - 1) tick();
        check("to_not_yet", timeout_o, 64'd0);
        tick();
        check("to_set", timeout_o, 64'd1);
        pulse_ready(32'h0, 1'b0);
        req_i = '0;
        repeat (2) tick();
        check("to_sticky", timeout_o, 64'd1);
        do_reset();
`endif

        // Random traffic checked cycle by cycle against the model.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int k = 0; k < NR; k++) begin
                if (ack_o[k[GW-1:0]]) begin
                    if ($urandom_range(0, 1) == 0) req_i[k[GW-1:0]] = 1'b0;
                    else set_cmd(k, 1'($urandom_range(0, 1)), $urandom, $urandom);
                end else if (!req_i[k[GW-1:0]] && $urandom_range(0, 3) == 0) begin
                    set_cmd(k, 1'($urandom_range(0, 1)), $urandom, $urandom);
                    req_i[k[GW-1:0]] = 1'b1;
                end
            end
            m_ready  = ($urandom_range(0, 3) == 0);
            m_rdata  = $urandom;
            m_slverr = 1'($urandom_range(0, 1));
            tick();
        end
        req_i = '0;
        for (int i = 0; i < 30; i++) begin
            if (!busy_o) break;
            m_ready = 1'b1;
            tick();
        end
        m_ready = 1'b0;
        tick();
        check("drain_idle", busy_o, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
